// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side consumer for an async FIFO.
//
// Pops entries from the FIFO read port and presents them as a valid/ready stream. Everything
// runs on the read clock. Pops are issued on a credit basis so that at most two beats are ever
// buffered or in flight. The FIFO memory read latency is absorbed in a 2-entry skid buffer,
// which sustains one beat per cycle while the downstream is ready.
//
// Parameters:
//   DSIZE   data width, equal to the FIFO data width
//   RD_LAT  cycles from pop to valid fifo_rdata; 0 or 1
//
// Ports:
//   rclk         in   read-domain clock (posedge)
//   rrst         in   asynchronous active-high reset
//   fifo_rempty  in   FIFO empty flag
//   fifo_rdata   in   FIFO read data
//   fifo_rinc    out  FIFO read increment (combinational)
//   drain_en     in   1 = pops permitted; buffered beats are delivered either way
//   m_data       out  stream data (head of skid buffer)
//   m_valid      out  stream valid
//   m_ready      in   stream ready
//   beat_cnt     out  accepted-beat count, 16 bits, wraps
//
// Build option: define DRAIN_BEAT_CNT_EN to build the beat counter; otherwise beat_cnt is 0.
module fifo_rd_drain #(
    parameter int unsigned DSIZE  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             fifo_rempty,
    input  logic [DSIZE-1:0] fifo_rdata,
    output logic             fifo_rinc,
    input  logic             drain_en,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      beat_cnt
);

    logic [1:0]       occ_q, occ_d;
    logic             inflt_q, inflt_d;
    logic [DSIZE-1:0] buf0_q, buf0_d;
    logic [DSIZE-1:0] buf1_q, buf1_d;
    logic             xfer;
    logic             cap;
    logic [2:0]       pend;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf0_q;

    always_comb begin
        xfer = m_valid & m_ready;
        // Beats we are committed to after this edge. Counting the transfer here is what lets a
        // full buffer keep popping while the downstream drains it.
        pend      = {1'b0, occ_q} + {2'b00, inflt_q} - {2'b00, xfer};
        fifo_rinc = drain_en & ~fifo_rempty & ~rrst & (pend < 3'd2);

        cap     = (RD_LAT == 0) ? fifo_rinc : inflt_q;
        inflt_d = (RD_LAT == 0) ? 1'b0 : fifo_rinc;

        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (xfer) begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
        end
        // Capture lands behind whatever survives the transfer, keeping strict order.
        if (cap) begin
            if (occ_d == 2'd0) begin
                buf0_d = fifo_rdata;
            end else begin
                buf1_d = fifo_rdata;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            occ_q   <= 2'd0;
            inflt_q <= 1'b0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            occ_q   <= occ_d;
            inflt_q <= inflt_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
        end
    end

    occ_bound_a: assert property (@(posedge rclk) disable iff (rrst) occ_q <= 2'd2);

`ifdef DRAIN_BEAT_CNT_EN
    logic [15:0] beat_cnt_q;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            beat_cnt_q <= 16'h0000;
        end else if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 16'h0001;
        end
    end

    assign beat_cnt = beat_cnt_q;
`else
    assign beat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: drives an RD_LAT=0 and an RD_LAT=1 instance from the same stream
// controls, each with its own FIFO read port model, and checks every cycle against a
// transaction-level model (popped-but-undelivered beats with their availability time).
module tb_fifo_rd_drain;

    logic       clk = 1'b0;
    logic       rrst;
    logic       drain_en;
    logic       m_ready;
    logic       rempty [2];
    logic [7:0] rdata  [2];
    logic       rinc   [2];
    logic       valid  [2];
    logic [7:0] data   [2];
    logic [15:0] beat  [2];

    always #5 clk = ~clk;

    fifo_rd_drain #(.DSIZE(8), .RD_LAT(0)) u_lat0 (
        .rclk(clk), .rrst(rrst), .fifo_rempty(rempty[0]), .fifo_rdata(rdata[0]),
        .fifo_rinc(rinc[0]), .drain_en(drain_en), .m_data(data[0]), .m_valid(valid[0]),
        .m_ready(m_ready), .beat_cnt(beat[0])
    );

    fifo_rd_drain #(.DSIZE(8), .RD_LAT(1)) u_lat1 (
        .rclk(clk), .rrst(rrst), .fifo_rempty(rempty[1]), .fifo_rdata(rdata[1]),
        .fifo_rinc(rinc[1]), .drain_en(drain_en), .m_data(data[1]), .m_valid(valid[1]),
        .m_ready(m_ready), .beat_cnt(beat[1])
    );

    // FIFO contents (shared write side, one read pointer per instance)
    logic [7:0] mem [1024];
    int         wr;
    int         rd [2];
    logic [7:0] lat1_q;

    // Reference: beats popped but not yet delivered, with the cycle they become visible
    logic [7:0] rb_d [2][4];
    int         rb_t [2][4];
    int         rb_h [2];
    int         rb_n [2];
    int         bc   [2];
    int         cyc;

    int n_chk;
    int n_pass;

    typedef struct {
        bit         load;
        bit         en;
        bit         rdy;
        bit         r1;
        bit         v1;
        logic [7:0] d1;
        bit         r0;
        bit         v0;
        logic [7:0] d0;
    } vec_t;

    vec_t tbl [17];
    bit   tbl_on;
    vec_t cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, exp);
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr % 1024] = v;
        wr++;
    endtask

    task automatic load4();
        for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    endtask

    // One clock cycle: entered and left at a negedge.
    task automatic step();
        logic       er [2];
        logic       ev [2];
        logic       xf [2];
        logic [7:0] ed [2];
        rempty[0] = (rd[0] == wr);
        rdata[0]  = mem[rd[0] % 1024];
        rempty[1] = (rd[1] == wr);
        rdata[1]  = lat1_q;
        #1;
        for (int d = 0; d < 2; d++) begin
            ev[d] = !rrst && rb_n[d] > 0 && rb_t[d][rb_h[d]] <= cyc;
            ed[d] = rb_d[d][rb_h[d]];
            xf[d] = ev[d] & m_ready;
            er[d] = !rrst && drain_en && (rd[d] != wr) && ((rb_n[d] - int'(xf[d])) < 2);
            chk($sformatf("rinc_lat%0d", d), 32'(rinc[d]), 32'(er[d]));
            chk($sformatf("valid_lat%0d", d), 32'(valid[d]), 32'(ev[d]));
            if (rrst) chk($sformatf("rst_data_lat%0d", d), 32'(data[d]), 32'h0);
            else if (ev[d]) chk($sformatf("data_lat%0d", d), 32'(data[d]), 32'(ed[d]));
`ifdef DRAIN_BEAT_CNT_EN
            chk($sformatf("beat_lat%0d", d), 32'(beat[d]), bc[d] & 32'hFFFF);
`else
            chk($sformatf("beat_lat%0d", d), 32'(beat[d]), 32'h0);
`endif
        end
        if (tbl_on) begin
            chk("tbl_rinc_lat1", 32'(rinc[1]), 32'(cur.r1));
            chk("tbl_valid_lat1", 32'(valid[1]), 32'(cur.v1));
            if (cur.v1) chk("tbl_data_lat1", 32'(data[1]), 32'(cur.d1));
            chk("tbl_rinc_lat0", 32'(rinc[0]), 32'(cur.r0));
            chk("tbl_valid_lat0", 32'(valid[0]), 32'(cur.v0));
            if (cur.v0) chk("tbl_data_lat0", 32'(data[0]), 32'(cur.d0));
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rrst) begin
                rb_n[d] = 0;
                bc[d]   = 0;
            end else begin
                if (xf[d]) begin
                    rb_h[d] = (rb_h[d] + 1) % 4;
                    rb_n[d]--;
                    bc[d]++;
                end
                if (er[d]) begin
                    rb_d[d][(rb_h[d] + rb_n[d]) % 4] = mem[rd[d] % 1024];
                    rb_t[d][(rb_h[d] + rb_n[d]) % 4] = cyc + d;
                    rb_n[d]++;
                    if (d == 1) lat1_q = mem[rd[d] % 1024];
                    rd[d]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit en, input bit rdy);
        drain_en = en;
        m_ready  = rdy;
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int depth();
        return wr - ((rd[0] < rd[1]) ? rd[0] : rd[1]);
    endfunction

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; wr = 0; tbl_on = 0; lat1_q = 8'h00;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 0; rb_h[d] = 0; rb_n[d] = 0; bc[d] = 0;
        end
        rrst = 1'b1; drain_en = 1'b1; m_ready = 1'b1;

        // Reset with a non-empty FIFO: no pops, outputs quiet
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        @(negedge clk);
        run(3, 1'b1, 1'b1);
        rrst = 1'b0;
        run(8, 1'b1, 1'b1);

        // Directed vectors: free-flowing burst, then backpressure burst
        tbl[0]  = '{1, 1, 1, 1, 0, 8'h00, 1, 0, 8'h00};
        tbl[1]  = '{0, 1, 1, 1, 0, 8'h00, 1, 1, 8'h11};
        tbl[2]  = '{0, 1, 1, 1, 1, 8'h11, 1, 1, 8'h12};
        tbl[3]  = '{0, 1, 1, 1, 1, 8'h12, 1, 1, 8'h13};
        tbl[4]  = '{0, 1, 1, 0, 1, 8'h13, 0, 1, 8'h14};
        tbl[5]  = '{0, 1, 1, 0, 1, 8'h14, 0, 0, 8'h00};
        tbl[6]  = '{0, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00};
        tbl[7]  = '{1, 1, 0, 1, 0, 8'h00, 1, 0, 8'h00};
        tbl[8]  = '{0, 1, 0, 1, 0, 8'h00, 1, 1, 8'h11};
        tbl[9]  = '{0, 1, 0, 0, 1, 8'h11, 0, 1, 8'h11};
        tbl[10] = '{0, 1, 0, 0, 1, 8'h11, 0, 1, 8'h11};
        tbl[11] = '{0, 1, 0, 0, 1, 8'h11, 0, 1, 8'h11};
        tbl[12] = '{0, 1, 1, 1, 1, 8'h11, 1, 1, 8'h11};
        tbl[13] = '{0, 1, 1, 1, 1, 8'h12, 1, 1, 8'h12};
        tbl[14] = '{0, 1, 1, 0, 1, 8'h13, 0, 1, 8'h13};
        tbl[15] = '{0, 1, 1, 0, 1, 8'h14, 0, 1, 8'h14};
        tbl[16] = '{0, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00};
        tbl_on = 1;
        for (int i = 0; i < 17; i++) begin
            cur = tbl[i];
            if (cur.load) load4();
            drain_en = cur.en;
            m_ready  = cur.rdy;
            step();
        end
        tbl_on = 0;

        // drain_en drops after the first pop; in-flight beat still delivered, then resume
        load4();
        run(1, 1'b1, 1'b1);
        run(5, 1'b0, 1'b1);
        run(8, 1'b1, 1'b1);

        // Reset with a full skid buffer, then refill and restart
        load4();
        run(5, 1'b1, 1'b0);
        rrst = 1'b1;
        run(2, 1'b1, 1'b0);
        rrst = 1'b0;
        load4();
        run(12, 1'b1, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) != 0 && depth() < 32) push(8'($urandom));
            m_ready  = ($urandom_range(0, 3) != 0);
            drain_en = ($urandom_range(0, 7) != 0);
            rrst     = ($urandom_range(0, 199) == 0);
            step();
        end
        rrst = 1'b0;
        run(10, 1'b1, 1'b1);

`ifdef DRAIN_BEAT_CNT_EN
        begin
            int guard;
            rrst = 1'b1;
            run(2, 1'b1, 1'b1);
            rrst = 1'b0;
            guard = 0;
            while (bc[0] < 300 && guard < 2000) begin
                if (depth() < 8) push(8'($urandom));
                step();
                guard++;
            end
            chk("beat_cnt_300", 32'(beat[0]), 32'd300);
            guard = 0;
            while (bc[0] < 65536 && guard < 70000) begin
                if (depth() < 8) push(8'($urandom));
                step();
                guard++;
            end
            chk("beat_wrap_reach", 32'(bc[0]), 32'd65536);
            chk("beat_cnt_wrap", 32'(beat[0]), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
